// File: rtl/wb_scheduler_pkg.sv
// wb_sched_pkg: unit encoding, reservation entry type and latency decode shared by the scheduler.
package wb_sched_pkg;
    typedef enum logic [1:0] {ALU = 2'd0, MEM = 2'd1, FPU = 2'd2, DIV = 2'd3} unit_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        unit_e      unit;
    } wb_entry_t;

    function automatic int unit_latency(input logic [3:0] du, input int alu_lat, input int mem_lat,
                                        input int fpu_lat, input int div_lat);
        return du == 4'b0001 ? alu_lat : du == 4'b0010 ? mem_lat :
               du == 4'b0100 ? fpu_lat : du == 4'b1000 ? div_lat : 0;
    endfunction

    function automatic unit_e unit_code(input logic [3:0] du);
        return du[3] ? DIV : du[2] ? FPU : du[1] ? MEM : ALU;
    endfunction
endpackage

// File: rtl/wb_scheduler_if.sv
// wb_scheduler_if: dispatch candidate, issue handshake and writeback-owner signals.
interface wb_scheduler_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dispatch_unit;
    logic       reg_write;
    logic       fpu_reg_write;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [2:0] rs_used;
    logic [2:0] rs_fpu;
    logic       issue;
    logic       illegal;
    logic       wb_int_valid;
    logic [4:0] wb_int_rd;
    logic [1:0] wb_int_unit;
    logic       wb_fp_valid;
    logic [4:0] wb_fp_rd;
    logic [1:0] wb_fp_unit;
    logic       div_busy;

    modport master (
        output in_valid, dispatch_unit, reg_write, fpu_reg_write, rd, rs1, rs2, rs3, rs_used, rs_fpu,
        input  in_ready, issue, illegal, wb_int_valid, wb_int_rd, wb_int_unit,
               wb_fp_valid, wb_fp_rd, wb_fp_unit, div_busy
    );

    modport slave (
        input  in_valid, dispatch_unit, reg_write, fpu_reg_write, rd, rs1, rs2, rs3, rs_used, rs_fpu,
        output in_ready, issue, illegal, wb_int_valid, wb_int_rd, wb_int_unit,
               wb_fp_valid, wb_fp_rd, wb_fp_unit, div_busy
    );
endinterface

// File: rtl/wb_reservation_ring.sv
// wb_reservation_ring: shifting writeback reservation window for one register-file port,
// with slot-occupied, source-match and destination-match queries.
module wb_reservation_ring
    import wb_sched_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter bit EXCL_X0 = 1'b0,
    parameter int IW      = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ins_en,
    input  logic [IW-1:0]   ins_idx,
    input  wb_entry_t       ins_entry,
    input  logic [IW-1:0]   lat_idx,
    output logic            occupied,
    input  logic [2:0]      src_en,
    input  logic [2:0][4:0] src_rd,
    output logic            src_hit,
    input  logic            dst_en,
    input  logic [4:0]      dst_rd,
    output logic            dst_hit,
    output wb_entry_t       head
);
    wb_entry_t win_q [0:DEPTH];
    wb_entry_t win_d [0:DEPTH];

    // x0 on the integer port holds a slot but never creates a hazard
    function automatic logic hit(input wb_entry_t e, input logic [4:0] r);
        return e.valid && e.rd == r && !(EXCL_X0 && r == 5'd0);
    endfunction

    always_comb begin
        for (int j = 0; j < DEPTH; j++) win_d[j] = win_q[j+1];
        win_d[DEPTH] = '0;
        if (ins_en) win_d[ins_idx] = ins_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_q <= '{default: '0};
        else        win_q <= win_d;
    end

    always_comb begin
        src_hit = 1'b0;
        dst_hit = 1'b0;
        for (int j = 0; j <= DEPTH; j++) begin
            for (int k = 0; k < 3; k++)
                src_hit = src_hit | (j > 0 && src_en[k] && hit(win_q[j], src_rd[k]));
            dst_hit = dst_hit | (dst_en && IW'(j) >= lat_idx && hit(win_q[j], dst_rd));
        end
    end

    assign occupied = win_q[lat_idx].valid;
    assign head     = win_q[0];
endmodule

// File: rtl/wb_scheduler.sv
// wb_scheduler: issue-stage gate checking unit, writeback-port, RAW and WAW availability,
// and publishing the owner of each writeback port every cycle.
module wb_scheduler
    import wb_sched_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int MEM_LAT = 2,
    parameter int FPU_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input logic           clk,
    input logic           rst_n,
    wb_scheduler_if.slave bus
);
    localparam int IW = $clog2(DIV_LAT + 1);

    logic [3:0]      du;
    logic            has_unit, wr_any, malformed, ready, fire;
    logic [IW-1:0]   lat_idx, ins_idx;
    logic            int_occ, fp_occ, int_src_hit, fp_src_hit, int_dst_hit, fp_dst_hit;
    wb_entry_t       ins_entry, int_head, fp_head;
    logic [2:0][4:0] src_rd;
    logic [IW-1:0]   div_cnt_q, div_cnt_d;

    assign du        = bus.dispatch_unit;
    assign has_unit  = du != 4'b0;
    assign wr_any    = bus.reg_write | bus.fpu_reg_write;
    assign malformed = (has_unit && !$onehot(du)) || (bus.reg_write && bus.fpu_reg_write) ||
                       (wr_any && !has_unit);
    assign lat_idx   = IW'(unit_latency(du, ALU_LAT, MEM_LAT, FPU_LAT, DIV_LAT));
    assign ins_idx   = lat_idx - IW'(1);
    assign ins_entry = '{valid: 1'b1, rd: bus.rd, unit: unit_code(du)};
    assign src_rd    = {bus.rs3, bus.rs2, bus.rs1};

    assign ready = !malformed && !(bus.reg_write && int_occ) && !(bus.fpu_reg_write && fp_occ) &&
                   !(du[3] && div_cnt_q != '0) && !int_src_hit && !fp_src_hit &&
                   !int_dst_hit && !fp_dst_hit;
    assign fire  = bus.in_valid && ready;

    wb_reservation_ring #(.DEPTH(DIV_LAT), .EXCL_X0(1'b1)) u_int_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins_en   (fire && bus.reg_write && has_unit),
        .ins_idx  (ins_idx),
        .ins_entry(ins_entry),
        .lat_idx  (lat_idx),
        .occupied (int_occ),
        .src_en   (bus.rs_used & ~bus.rs_fpu),
        .src_rd   (src_rd),
        .src_hit  (int_src_hit),
        .dst_en   (bus.reg_write && has_unit),
        .dst_rd   (bus.rd),
        .dst_hit  (int_dst_hit),
        .head     (int_head)
    );

    wb_reservation_ring #(.DEPTH(DIV_LAT), .EXCL_X0(1'b0)) u_fp_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins_en   (fire && bus.fpu_reg_write && has_unit),
        .ins_idx  (ins_idx),
        .ins_entry(ins_entry),
        .lat_idx  (lat_idx),
        .occupied (fp_occ),
        .src_en   (bus.rs_used & bus.rs_fpu),
        .src_rd   (src_rd),
        .src_hit  (fp_src_hit),
        .dst_en   (bus.fpu_reg_write && has_unit),
        .dst_rd   (bus.rd),
        .dst_hit  (fp_dst_hit),
        .head     (fp_head)
    );

    // Divider is non-pipelined: the counter spans the whole DIV initiation interval
    always_comb begin
        div_cnt_d = div_cnt_q != '0 ? div_cnt_q - IW'(1) : div_cnt_q;
        if (fire && du[3]) div_cnt_d = IW'(DIV_LAT - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end

    assign bus.in_ready     = ready;
    assign bus.issue        = fire;
    assign bus.illegal      = bus.in_valid && malformed;
    assign bus.div_busy     = div_cnt_q != '0;
    assign bus.wb_int_valid = int_head.valid;
    assign bus.wb_int_rd    = int_head.rd;
    assign bus.wb_int_unit  = int_head.unit;
    assign bus.wb_fp_valid  = fp_head.valid;
    assign bus.wb_fp_rd     = fp_head.rd;
    assign bus.wb_fp_unit   = fp_head.unit;
endmodule

// File: tb/tb_wb_scheduler.sv
// tb_wb_scheduler: directed test-plan scenarios plus random traffic against a timestamped
// pending-writeback model; a monitor pops expected writebacks as the DUT presents them.
module tb_wb_scheduler;
    localparam int ALU_LAT = 1;
    localparam int MEM_LAT = 2;
    localparam int FPU_LAT = 3;
    localparam int DIV_LAT = 8;

    typedef struct packed {
        logic [3:0]      du;
        logic            rw;
        logic            fw;
        logic [4:0]      rd;
        logic [2:0][4:0] rs;
        logic [2:0]      used;
        logic [2:0]      fpu;
    } cand_t;

    typedef struct {
        int         land;
        bit         fp;
        logic [4:0] rd;
        int         unit;
    } pend_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   last_div = -100;
    pend_t sb[$];

    wb_scheduler_if bus();

    wb_scheduler #(.ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT), .FPU_LAT(FPU_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int lat_of(input logic [3:0] du);
        return du[0] ? ALU_LAT : du[1] ? MEM_LAT : du[2] ? FPU_LAT : du[3] ? DIV_LAT : 0;
    endfunction

    function automatic int unit_of(input logic [3:0] du);
        return du[0] ? 0 : du[1] ? 1 : du[2] ? 2 : 3;
    endfunction

    function automatic bit bad(input cand_t c);
        return (c.du != 0 && !$onehot(c.du)) || (c.rw && c.fw) || ((c.rw || c.fw) && c.du == 0);
    endfunction

    function automatic bit busy_at(input int t);
        return t > last_div && t < last_div + DIV_LAT;
    endfunction

    function automatic bit same_reg(input pend_t e, input bit fp, input logic [4:0] r);
        return e.fp == fp && e.rd == r && (fp || r != 0);
    endfunction

    function automatic bit model_ready(input int t, input cand_t c);
        int l;
        bit wr;
        l = lat_of(c.du);
        wr = (c.rw || c.fw) && c.du != 0;
        if (bad(c)) return 0;
        if (c.du[3] && busy_at(t)) return 0;
        foreach (sb[i]) begin
            if (wr && sb[i].fp == c.fw && sb[i].land == t + l) return 0;
            if (wr && same_reg(sb[i], c.fw, c.rd) && sb[i].land - t >= l) return 0;
            for (int k = 0; k < 3; k++)
                if (c.used[k] && same_reg(sb[i], c.fpu[k], c.rs[k]) && sb[i].land > t) return 0;
        end
        return 1;
    endfunction

    function automatic cand_t mk(input logic [3:0] du, input bit rw, input bit fw, input int rd,
                                 input int rs1, input logic [2:0] used, input logic [2:0] fpu);
        cand_t c;
        c = '0;
        c.du = du;
        c.rw = rw;
        c.fw = fw;
        c.rd = 5'(rd);
        c.rs[0] = 5'(rs1);
        c.used = used;
        c.fpu = fpu;
        return c;
    endfunction

    task automatic step(input cand_t c, input bit v, output bit iss);
        bit rdy;
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.dispatch_unit = c.du;
        bus.reg_write = c.rw;
        bus.fpu_reg_write = c.fw;
        bus.rd = c.rd;
        bus.rs1 = c.rs[0];
        bus.rs2 = c.rs[1];
        bus.rs3 = c.rs[2];
        bus.rs_used = c.used;
        bus.rs_fpu = c.fpu;
        #1;
        rdy = model_ready(cyc, c);
        chk("in_ready", int'(bus.in_ready), int'(rdy));
        chk("illegal", int'(bus.illegal), int'(v && bad(c)));
        chk("issue", int'(bus.issue), int'(v && rdy));
        chk("div_busy", int'(bus.div_busy), int'(busy_at(cyc)));
        iss = v && rdy;
        if (iss) begin
            if (c.du[3]) last_div = cyc;
            if ((c.rw || c.fw) && c.du != 0)
                sb.push_back('{land: cyc + lat_of(c.du), fp: c.fw, rd: c.rd, unit: unit_of(c.du)});
        end
    endtask

    task automatic idle(input int n);
        bit d;
        for (int i = 0; i < n; i++) step('0, 1'b0, d);
    endtask

    task automatic issue_until(input string name, input cand_t c, input int exp_wait);
        bit iss;
        int w;
        iss = 0;
        w = 0;
        while (!iss && w < 20) begin
            step(c, 1'b1, iss);
            if (!iss) w++;
        end
        chk(name, w, exp_wait);
    endtask

    always @(negedge clk) begin
        pend_t ei, ef;
        bit hi, hf;
        hi = 0;
        hf = 0;
        ei = '{default: 0};
        ef = '{default: 0};
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].land == cyc) begin
                if (sb[i].fp) begin hf = 1; ef = sb[i]; end
                else begin hi = 1; ei = sb[i]; end
                sb.delete(i);
            end
        chk("wb_int_valid", int'(bus.wb_int_valid), int'(hi));
        if (hi) begin
            chk("wb_int_rd", int'(bus.wb_int_rd), int'(ei.rd));
            chk("wb_int_unit", int'(bus.wb_int_unit), ei.unit);
        end
        chk("wb_fp_valid", int'(bus.wb_fp_valid), int'(hf));
        if (hf) begin
            chk("wb_fp_rd", int'(bus.wb_fp_rd), int'(ef.rd));
            chk("wb_fp_unit", int'(bus.wb_fp_unit), ef.unit);
        end
    end

    initial begin
        cand_t c;
        bit d;
        int r, w;
        bus.in_valid = 0;
        bus.dispatch_unit = 0;
        bus.reg_write = 0;
        bus.fpu_reg_write = 0;
        bus.rd = 0;
        bus.rs1 = 0;
        bus.rs2 = 0;
        bus.rs3 = 0;
        bus.rs_used = 0;
        bus.rs_fpu = 0;
        #2;
        chk("rst_wb_int_valid", int'(bus.wb_int_valid), 0);
        chk("rst_wb_int_rd", int'(bus.wb_int_rd), 0);
        chk("rst_wb_int_unit", int'(bus.wb_int_unit), 0);
        chk("rst_wb_fp_valid", int'(bus.wb_fp_valid), 0);
        chk("rst_wb_fp_rd", int'(bus.wb_fp_rd), 0);
        chk("rst_wb_fp_unit", int'(bus.wb_fp_unit), 0);
        chk("rst_div_busy", int'(bus.div_busy), 0);
        chk("rst_illegal", int'(bus.illegal), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        issue_until("port_fpu_wait", mk(4'b0100, 0, 1, 1, 0, 3'b000, 3'b000), 0);
        issue_until("port_mem_wait", mk(4'b0010, 0, 1, 2, 0, 3'b000, 3'b000), 1);
        idle(10);
        issue_until("raw_int_prod", mk(4'b0001, 1, 0, 5, 0, 3'b000, 3'b000), 0);
        issue_until("raw_int_cons", mk(4'b0001, 1, 0, 6, 5, 3'b001, 3'b000), 0);
        idle(10);
        issue_until("raw_fp_prod", mk(4'b0100, 0, 1, 5, 0, 3'b000, 3'b000), 0);
        issue_until("raw_fp_cons", mk(4'b0100, 0, 1, 6, 5, 3'b001, 3'b001), 2);
        idle(10);
        issue_until("x0_prod", mk(4'b0001, 1, 0, 0, 0, 3'b000, 3'b000), 0);
        issue_until("x0_cons", mk(4'b0001, 1, 0, 0, 0, 3'b001, 3'b000), 0);
        idle(10);
        issue_until("waw_div", mk(4'b1000, 0, 1, 7, 0, 3'b000, 3'b000), 0);
        issue_until("waw_fpu", mk(4'b0100, 0, 1, 7, 0, 3'b000, 3'b000), 5);
        idle(12);
        issue_until("div_first", mk(4'b1000, 0, 1, 8, 0, 3'b000, 3'b000), 0);
        issue_until("div_second", mk(4'b1000, 0, 1, 9, 0, 3'b000, 3'b000), 7);
        step(mk(4'b0110, 0, 0, 1, 0, 3'b000, 3'b000), 1'b1, d);
        chk("illegal_0110", int'(bus.illegal), 1);
        chk("illegal_ready", int'(bus.in_ready), 0);
        idle(12);

        issue_until("rst_fpu", mk(4'b0100, 0, 1, 1, 0, 3'b000, 3'b000), 0);
        issue_until("rst_div", mk(4'b1000, 0, 1, 2, 0, 3'b000, 3'b000), 0);
        issue_until("rst_alu", mk(4'b0001, 1, 0, 3, 0, 3'b000, 3'b000), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        #1;
        chk("pre_rst_int_valid", int'(bus.wb_int_valid), 1);
        chk("pre_rst_fp_valid", int'(bus.wb_fp_valid), 1);
        rst_n = 1'b0;
        sb.delete();
        last_div = -100;
        #1;
        chk("async_rst_int_valid", int'(bus.wb_int_valid), 0);
        chk("async_rst_fp_valid", int'(bus.wb_fp_valid), 0);
        chk("async_rst_div_busy", int'(bus.div_busy), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(12);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            c = '0;
            c.du = r < 2 ? 4'b0001 : r < 4 ? 4'b0010 : r < 6 ? 4'b0100 : r == 6 ? 4'b1000 :
                   r == 7 ? 4'b0000 : 4'($urandom);
            w = $urandom_range(0, 9);
            c.rw = w < 4 || w == 8;
            c.fw = (w >= 4 && w < 8) || w == 8;
            if (c.du == 0 && $urandom_range(0, 3) != 0) begin
                c.rw = 0;
                c.fw = 0;
            end
            c.rd = 5'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) c.rs[k] = 5'($urandom_range(0, 7));
            c.used = 3'($urandom);
            c.fpu = 3'($urandom);
            step(c, $urandom_range(0, 3) != 0, d);
        end
        idle(DIV_LAT + 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
